// File: rtl/holo_pkg.sv
// Shared types and the wrapped phase-difference helper for the phased-array output stage.
package holo_pkg;

    localparam int DEFAULT_PERIOD   = 1250;
    localparam int DEFAULT_CHANNELS = 128;
    localparam int DEFAULT_CNT_W    = $clog2(DEFAULT_PERIOD);
    localparam int DEFAULT_CH_W     = $clog2(DEFAULT_CHANNELS);

    typedef logic [DEFAULT_CNT_W-1:0] cnt_t;
    typedef logic [DEFAULT_CH_W-1:0]  ch_idx_t;

    // (counter - phase) mod period; both operands are already below period.
    function automatic logic [31:0] phase_diff(input logic [31:0] counter,
                                               input logic [31:0] phase,
                                               input logic [31:0] period);
        logic [31:0] diff;
        diff = counter - phase;
        if (counter < phase) begin
            diff = diff + period;
        end
        return diff;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for the asynchronous alignment input plus a rising-edge detector.
// rise is a one-cycle strobe that is high in the cycle after the second sync flop first captures a 1.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/phased_array_driver.sv
// Phase-shifted square-wave generator with a double-buffered phase/duty bank that is swapped
// only on a carrier wrap; the carrier can be realigned to an upstream board via sync_in.
module phased_array_driver
    import holo_pkg::*;
#(
    parameter int NUM_CHANNELS = DEFAULT_CHANNELS,
    parameter int PERIOD       = DEFAULT_PERIOD,
    parameter int CNT_W        = $clog2(PERIOD),
    parameter int CH_W         = $clog2(NUM_CHANNELS)
) (
    input  logic                    sys_clk,
    input  logic                    ext_rst,
    input  logic                    slave_mode,
    input  logic                    sync_in,
    output logic                    sync_out,
    input  logic                    out_en,
    input  logic                    wr_en,
    input  logic [CH_W-1:0]         wr_addr,
    input  logic [CNT_W-1:0]        wr_phase,
    output logic                    wr_ready,
    input  logic [CNT_W-1:0]        duty_in,
    input  logic                    commit,
    output logic                    pending,
    output logic                    err,
    output logic [NUM_CHANNELS-1:0] trans
);

    // Duty carries one extra bit so a full-period duty is representable for any PERIOD.
    localparam int                DUTY_W   = CNT_W + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(PERIOD);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    sync_out_q, sync_out_d;
    logic                    pending_q, pending_d;
    logic                    err_q, err_d;
    logic [NUM_CHANNELS-1:0] trans_q, trans_d;
    logic [CNT_W-1:0]        shadow_phase_q [NUM_CHANNELS];
    logic [CNT_W-1:0]        shadow_phase_d [NUM_CHANNELS];
    logic [CNT_W-1:0]        active_phase_q [NUM_CHANNELS];
    logic [CNT_W-1:0]        active_phase_d [NUM_CHANNELS];
    logic [DUTY_W-1:0]       shadow_duty_q, shadow_duty_d;
    logic [DUTY_W-1:0]       active_duty_q, active_duty_d;

    logic sync_rise;
    logic wrap;
    logic wr_acc;
    logic commit_acc;
    logic wr_bad;

    sync_edge_detect u_sync (
        .clk      (sys_clk),
        .rst      (ext_rst),
        .async_in (sync_in),
        .rise     (sync_rise)
    );

    always_comb begin
        wrap       = (cnt_q == CNT_LAST) || (slave_mode && sync_rise);
        cnt_d      = wrap ? '0 : cnt_q + CNT_W'(1);
        sync_out_d = (cnt_q == '0);

        wr_acc     = wr_en && !pending_q;
        commit_acc = commit && !pending_q;
        wr_bad     = (32'(wr_addr) >= 32'(NUM_CHANNELS)) || (32'(wr_phase) >= 32'(PERIOD));

        shadow_phase_d = shadow_phase_q;
        active_phase_d = active_phase_q;
        shadow_duty_d  = shadow_duty_q;
        active_duty_d  = active_duty_q;
        pending_d      = pending_q;
        err_d          = err_q;

        if (wr_acc) begin
            if (wr_bad) begin
                err_d = 1'b1;
            end else begin
                shadow_phase_d[wr_addr] = wr_phase;
            end
        end

        if (commit_acc) begin
            pending_d     = 1'b1;
            shadow_duty_d = (32'(duty_in) > 32'(PERIOD)) ? DUTY_MAX : {1'b0, duty_in};
        end

        // Shadow is frozen while pending, so the swap never races a host write.
        if (wrap && pending_q) begin
            active_phase_d = shadow_phase_q;
            active_duty_d  = shadow_duty_q;
            pending_d      = 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        assign trans_d[i] = out_en &&
            (phase_diff(32'(cnt_q), 32'(active_phase_q[i]), 32'(PERIOD)) < 32'(active_duty_q));
    end

    always_ff @(posedge sys_clk) begin
        if (ext_rst) begin
            cnt_q         <= '0;
            sync_out_q    <= 1'b0;
            pending_q     <= 1'b0;
            err_q         <= 1'b0;
            trans_q       <= '0;
            shadow_duty_q <= '0;
            active_duty_q <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                shadow_phase_q[i] <= '0;
                active_phase_q[i] <= '0;
            end
        end else begin
            cnt_q          <= cnt_d;
            sync_out_q     <= sync_out_d;
            pending_q      <= pending_d;
            err_q          <= err_d;
            trans_q        <= trans_d;
            shadow_duty_q  <= shadow_duty_d;
            active_duty_q  <= active_duty_d;
            shadow_phase_q <= shadow_phase_d;
            active_phase_q <= active_phase_d;
        end
    end

    assign sync_out = sync_out_q;
    assign pending  = pending_q;
    assign err      = err_q;
    assign trans    = trans_q;
    assign wr_ready = ~pending_q;

endmodule
